// File: rtl/scanchain_reader.sv
// Scan chain read-back engine: shifts an address in, pulses capture, then shifts the payload out.
// Define SCANCHAIN_READER_SYNC_EN to pass scan_out through a 2-flop synchronizer.

module scanchain_reader #(
  parameter int CLOCK_FREQ          = 100_000_000,
  parameter int CLOCKS_PER_SCAN_CLK = 100_000,
  parameter int ADDR_BITS           = 12,
  parameter int PAYLOAD_BITS        = 169
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    read_valid,
  output logic                    read_ready,
  input  logic [ADDR_BITS-1:0]    read_addr,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [PAYLOAD_BITS-1:0] resp_data,
  output logic                    busy,
  output logic                    scan_clk,
  output logic                    scan_en,
  output logic                    scan_in,
  input  logic                    scan_out
);

  localparam int C    = CLOCKS_PER_SCAN_CLK;
  localparam int DW   = $clog2(C);
  localparam int MAXB = (ADDR_BITS > PAYLOAD_BITS) ? ADDR_BITS : PAYLOAD_BITS;
  localparam int BW   = $clog2(MAXB + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(C - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(C / 2);
  localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_BITS - 1);
  localparam logic [BW-1:0] PAY_LAST  = BW'(PAYLOAD_BITS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  if (C < 4 || (C % 2) != 0 || CLOCK_FREQ <= 0) begin : g_bad_cfg
    $error("scanchain_reader: CLOCKS_PER_SCAN_CLK must be even and >= 4");
  end

  logic [2:0]              state_q, state_d;
  logic [DW-1:0]           div_q, div_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    sclk_q, sclk_d;
  logic                    sen_q, sen_d;
  logic                    sin_q, sin_d;
  logic                    sample_bit;
  logic                    bit_end;

`ifdef SCANCHAIN_READER_SYNC_EN
  // Synchronizer delay of two clk cycles pushes the sample point past mid-period.
  localparam logic [DW-1:0] SAMPLE_AT = DW'(C / 2 + 1);
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= scan_out;
      sync2_q <= sync1_q;
    end
  end

  assign sample_bit = sync2_q;
`else
  localparam logic [DW-1:0] SAMPLE_AT = DW'(C / 2 - 1);
  assign sample_bit = scan_out;
`endif

  assign bit_end = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    addr_d  = addr_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    sen_d   = sen_q;
    sin_d   = sin_q;

    if (state_q == S_ADDR || state_q == S_CAPTURE || state_q == S_SHIFT) begin
      div_d = bit_end ? '0 : div_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (read_valid) begin
          state_d = S_ADDR;
          addr_d  = read_addr;
          shreg_d = '0;
          div_d   = '0;
          bit_d   = '0;
          sen_d   = 1'b1;
          sin_d   = read_addr[ADDR_BITS-1];
        end
      end
      S_ADDR: begin
        if (bit_end) begin
          if (bit_q == ADDR_LAST) begin
            state_d = S_CAPTURE;
            bit_d   = '0;
            sen_d   = 1'b0;
            sin_d   = 1'b0;
          end else begin
            bit_d  = bit_q + 1'b1;
            addr_d = addr_q << 1;
            sin_d  = addr_d[ADDR_BITS-1];
          end
        end
      end
      S_CAPTURE: begin
        if (bit_end) begin
          state_d = S_SHIFT;
          sen_d   = 1'b1;
          sin_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        if (div_q == SAMPLE_AT) begin
          shreg_d = {shreg_q[PAYLOAD_BITS-2:0], sample_bit};
        end
        // The final sample may land on the same edge as the period end, so load from shreg_d.
        if (bit_end) begin
          if (bit_q == PAY_LAST) begin
            state_d = S_RESP;
            bit_d   = '0;
            data_d  = shreg_d;
            valid_d = 1'b1;
            sen_d   = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    sclk_d = (state_d == S_ADDR || state_d == S_CAPTURE || state_d == S_SHIFT) &&
             (div_d >= DIV_HALF);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      addr_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sclk_q  <= 1'b0;
      sen_q   <= 1'b0;
      sin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      addr_q  <= addr_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sclk_q  <= sclk_d;
      sen_q   <= sen_d;
      sin_q   <= sin_d;
    end
  end

  assign read_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = valid_q;
  assign resp_data  = data_q;
  assign scan_clk   = sclk_q;
  assign scan_en    = sen_q;
  assign scan_in    = sin_q;

endmodule

// File: tb/tb_scanchain_reader.sv
// Self-checking bench for scanchain_reader with a small chip model whose scan_out lags one clk.
// Works with or without SCANCHAIN_READER_SYNC_EN defined.

module tb_scanchain_reader;

  localparam int C  = 4;
  localparam int AB = 4;
  localparam int PB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          read_valid = 1'b0;
  logic          resp_ready = 1'b0;
  logic [AB-1:0] read_addr = '0;
  logic          read_ready, resp_valid, busy, scan_clk, scan_en, scan_in, scan_out;
  logic [PB-1:0] resp_data;

  int            checks = 0;
  int            errors = 0;
  logic [PB-1:0] expectQ[$];
  bit            timingOn = 1'b0;

  typedef struct {
    logic [AB-1:0] addr;
    int            readyDelay;
    logic [PB-1:0] expData;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  scanchain_reader #(
    .CLOCK_FREQ(100_000_000),
    .CLOCKS_PER_SCAN_CLK(C),
    .ADDR_BITS(AB),
    .PAYLOAD_BITS(PB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .read_valid(read_valid),
    .read_ready(read_ready),
    .read_addr(read_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .busy(busy),
    .scan_clk(scan_clk),
    .scan_en(scan_en),
    .scan_in(scan_in),
    .scan_out(scan_out)
  );

  // Chip model: shifts on scan_clk rise with scan_en=1, captures a per-address payload with scan_en=0.
  function automatic logic [7:0] chipPayload(input logic [3:0] a);
    case (a)
      4'hA:    return 8'hC3;
      4'h3:    return 8'h5A;
      4'hC:    return 8'hE7;
      default: return {a, ~a};
    endcase
  endfunction

  logic       prevSclkChip = 1'b0;
  logic [3:0] chipAddr = '0;
  logic [7:0] chipSr = '0;
  logic       chipOut = 1'b0;

  always @(posedge clk) begin
    prevSclkChip <= scan_clk;
    if (scan_clk && !prevSclkChip) begin
      if (scan_en) begin
        chipAddr <= {chipAddr[2:0], scan_in};
        chipSr   <= {chipSr[6:0], 1'b0};
      end else begin
        chipSr <= chipPayload(chipAddr);
      end
    end
    chipOut <= chipSr[7];
  end

  assign scan_out = chipOut;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s timed out", name);
  endtask

  // Drives one request from a negedge and records the payload the chip will return.
  task automatic applyStimulus(input logic [AB-1:0] addr, input logic [PB-1:0] expData);
    int n = 0;
    while (!read_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!read_ready) timeoutFail("requestAccept");
    read_valid = 1'b1;
    read_addr  = addr;
    expectQ.push_back(expData);
    @(negedge clk);
    read_valid = 1'b0;
  endtask

  task automatic waitRespValid();
    int n = 0;
    while (!resp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) timeoutFail("respValid");
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!read_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!read_ready) timeoutFail("returnIdle");
  endtask

  // Scoreboard: a response transfer is sampled just before the edge that completes it.
  always @(negedge clk) begin
    #4;
    if (reset && resp_valid && resp_ready) begin
      if (expectQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL respUnexpected got 0x%0h with no request outstanding", resp_data);
      end else begin
        checkOutput("respData", resp_data, expectQ.pop_front());
      end
    end
  end

  // Scan clock shape and pin stability while scan_clk is high.
  int   highCnt = 0;
  int   lowCnt = 0;
  logic prevClkN = 1'b0;
  logic lastSin = 1'b0;
  logic lastSen = 1'b0;

  always @(negedge clk) begin
    if (!timingOn || !reset) begin
      highCnt = 0;
      lowCnt  = 0;
    end else if (scan_clk) begin
      if (prevClkN) begin
        checkOutput("scanInStable", scan_in, lastSin);
        checkOutput("scanEnStable", scan_en, lastSen);
      end else begin
        checkOutput("scanClkLow", lowCnt, C / 2);
      end
      highCnt++;
      lowCnt = 0;
    end else begin
      if (prevClkN) checkOutput("scanClkHigh", highCnt, C / 2);
      highCnt = 0;
      if (busy) lowCnt++;
      else lowCnt = 0;
    end
    prevClkN = scan_clk;
    lastSin  = scan_in;
    lastSen  = scan_en;
  end

  initial begin
    int         k;
    int         rises;
    int         n;
    logic       prev;
    logic [3:0] seq;
    logic       senAll;
    logic       capEn;

    vecs[0] = '{4'hA, 0, 8'hC3};
    vecs[1] = '{4'h3, 2, 8'h5A};
    vecs[2] = '{4'hC, 0, 8'hE7};
    vecs[3] = '{4'h0, 5, 8'h0F};
    vecs[4] = '{4'h7, 1, 8'h78};
    vecs[5] = '{4'hF, 3, 8'hF0};

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      read_valid = 1'($urandom_range(0, 1));
      read_addr  = 4'($urandom);
      resp_ready = 1'($urandom_range(0, 1));
      #1;
      checkOutput("resetOutputs", {scan_clk, scan_en, scan_in, resp_valid, busy}, 5'b0);
      checkOutput("resetData", resp_data, 0);
    end
    @(negedge clk);
    read_valid = 1'b0;
    resp_ready = 1'b1;
    reset      = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterReset", read_ready, 1);
    checkOutput("busyAfterReset", busy, 0);
    timingOn = 1'b1;

    // Basic read: address sequence, capture pulse, latency
    read_valid = 1'b1;
    read_addr  = 4'hA;
    expectQ.push_back(8'hC3);
    @(posedge clk);
    @(negedge clk);
    read_valid = 1'b0;
    k      = 0;
    rises  = 0;
    seq    = '0;
    senAll = 1'b1;
    capEn  = 1'b1;
    prev   = scan_clk;
    while (!resp_valid && k < 200) begin
      @(negedge clk);
      k++;
      if (scan_clk && !prev) begin
        rises++;
        if (rises <= 4) begin
          seq    = {seq[2:0], scan_in};
          senAll = senAll & scan_en;
        end else if (rises == 5) begin
          capEn = scan_en;
        end
      end
      prev = scan_clk;
    end
    checkOutput("latency", k, 52);
    checkOutput("addrSequence", seq, 4'b1010);
    checkOutput("addrScanEn", senAll, 1);
    checkOutput("captureScanEn", capEn, 0);
    checkOutput("scanClkRises", rises, 13);
    waitIdle();

    // Table-driven reads with varying response delay
    for (int i = 0; i < 6; i++) begin
      resp_ready = (vecs[i].readyDelay == 0);
      applyStimulus(vecs[i].addr, vecs[i].expData);
      if (vecs[i].readyDelay > 0) begin
        waitRespValid();
        repeat (vecs[i].readyDelay) @(negedge clk);
        resp_ready = 1'b1;
      end
      waitIdle();
    end

    // Backpressure: response held, new requests ignored
    resp_ready = 1'b0;
    applyStimulus(4'hA, 8'hC3);
    waitRespValid();
    read_valid = 1'b1;
    read_addr  = 4'h5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("bpFlags", {resp_valid, busy, read_ready, scan_clk}, 4'b1100);
      checkOutput("bpData", resp_data, 8'hC3);
    end
    read_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bpExitIdle", {read_ready, resp_valid}, 2'b10);

    // Back-to-back requests with resp_ready tied high
    read_valid = 1'b1;
    read_addr  = 4'h3;
    expectQ.push_back(8'h5A);
    @(negedge clk);
    read_addr = 4'hC;
    expectQ.push_back(8'hE7);
    n = 0;
    while (!resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) timeoutFail("b2bFirstResp");
    @(negedge clk);
    checkOutput("b2bIdle", read_ready, 1);
    @(negedge clk);
    checkOutput("b2bAccept", busy, 1);
    read_valid = 1'b0;
    waitRespValid();
    waitIdle();

    // Reset during SHIFT bit 3, then a clean read
    timingOn = 1'b0;
    applyStimulus(4'h7, 8'h78);
    rises = 0;
    n     = 0;
    prev  = scan_clk;
    while (rises < 9 && n < 200) begin
      @(negedge clk);
      n++;
      if (scan_clk && !prev) rises++;
      prev = scan_clk;
    end
    if (rises < 9) timeoutFail("shiftBit3");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("abortPins", {scan_clk, scan_en, scan_in, resp_valid, busy}, 5'b0);
    checkOutput("abortData", resp_data, 0);
    expectQ.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterAbort", read_ready, 1);
    timingOn = 1'b1;
    applyStimulus(4'h7, 8'h78);
    waitRespValid();
    waitIdle();

    @(negedge clk);
    checkOutput("scoreboardDrained", expectQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
